// File: rtl/alu_defs.sv
// Shared ALU definitions: loader FSM state codes and ALU opcodes.
// Used by both the operand loader and the ALU itself.
package alu_defs;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        SHOW    = 2'd3
    } state_e;

    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] AND = 2'd2;
    localparam logic [1:0] XOR = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, level debouncer and
// registered one-cycle pulse on an accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          acc_q;
    logic          prev_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            acc_q   <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            if (s2_q == acc_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                acc_q <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            // Edge detect on the accepted level; falling edges are ignored.
            prev_q  <= acc_q;
            pulse_q <= acc_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Step-through operand entry for an ALU: A, then B, then opcode,
// then a SHOW state where the operands are presented as valid.
module alu_operand_loader
    import alu_defs::*;
#(
    parameter int DATA_WIDTH      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] sw,
    input  logic                  btn_next,
    input  logic                  btn_clr,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [1:0]            opcode,
    output logic [1:0]            stage,
    output logic                  valid
);

    logic                  next_pulse;
    logic                  clr_pulse;
    logic [1:0]            sw_op;
    state_e                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [1:0]            op_q;
    logic                  valid_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_i   (btn_next),
        .pulse_o (next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_i   (btn_clr),
        .pulse_o (clr_pulse)
    );

    generate
        if (DATA_WIDTH >= 2) begin : g_op_wide
            assign sw_op = sw[1:0];
        end else begin : g_op_narrow
            assign sw_op = {1'b0, sw[0]};
        end
    endgenerate

    // Clear takes priority over a coincident next.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else if (clr_pulse) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else if (next_pulse) begin
            unique case (state_q)
                LOAD_A: begin
                    a_q     <= sw;
                    state_q <= LOAD_B;
                    valid_q <= 1'b0;
                end
                LOAD_B: begin
                    b_q     <= sw;
                    state_q <= LOAD_OP;
                    valid_q <= 1'b0;
                end
                LOAD_OP: begin
                    op_q    <= sw_op;
                    state_q <= SHOW;
                    valid_q <= 1'b1;
                end
                SHOW: begin
                    state_q <= LOAD_A;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= LOAD_A;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign opcode = op_q;
    assign stage  = state_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a scoreboard of
// expected output snapshots (A, B, opcode, stage, valid).
module tb_alu_operand_loader;

    localparam int DW = 4;
    localparam int DB = 16;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    op;
        logic [1:0]    st;
        logic          v;
    } snap_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] sw = '0;
    logic          btn_next = 1'b0;
    logic          btn_clr = 1'b0;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [1:0]    opcode;
    logic [1:0]    stage;
    logic          valid;

    int checks = 0;
    int errors = 0;

    snap_t q[$];
    snap_t m;

    alu_operand_loader #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .sw       (sw),
        .btn_next (btn_next),
        .btn_clr  (btn_clr),
        .A        (A),
        .B        (B),
        .opcode   (opcode),
        .stage    (stage),
        .valid    (valid)
    );

    always #5 CLK = ~CLK;

    function automatic snap_t actual();
        return {A, B, opcode, stage, valid};
    endfunction

    function automatic void model_reset();
        m = '0;
    endfunction

    function automatic void model_next(input logic [DW-1:0] s);
        case (m.st)
            2'd0: begin m.a = s; m.st = 2'd1; end
            2'd1: begin m.b = s; m.st = 2'd2; end
            2'd2: begin m.op = s[1:0]; m.st = 2'd3; end
            default: m.st = 2'd0;
        endcase
        m.v = (m.st == 2'd3);
    endfunction

    // Stimulus only: hold buttons steady long enough to debounce, then release.
    task automatic press(input bit nxt, input bit clr, input logic [DW-1:0] s);
        sw = s;
        @(negedge CLK);
        btn_next = nxt;
        btn_clr  = clr;
        repeat (25) @(negedge CLK);
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        repeat (25) @(negedge CLK);
    endtask

    task automatic test_reset();
        snap_t e;
        snap_t g;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        model_reset();
        q.push_back(m);
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_init got=%h exp=%h", g, e);
        end
        press(1'b1, 1'b0, 4'h5);
        model_next(4'h5);
        q.push_back(m);
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_preload got=%h exp=%h", g, e);
        end
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        model_reset();
        q.push_back(m);
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", g, e);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_full_entry();
        logic [DW-1:0] vals[4] = '{4'h9, 4'h3, 4'h1, 4'h6};
        snap_t e;
        snap_t g;
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0, vals[i]);
            model_next(vals[i]);
            q.push_back(m);
            e = q.pop_front();
            g = actual();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL entry_%0d got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_sw_no_effect();
        snap_t e;
        snap_t g;
        q.push_back(m);
        for (int i = 0; i < 8; i++) begin
            sw = DW'($urandom_range(0, 15));
            repeat (3) @(negedge CLK);
        end
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL sw_no_effect got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_bounce();
        int trans = 0;
        logic [1:0] prev;
        logic [1:0] st18 = 2'd0;
        logic [1:0] st19 = 2'd0;
        snap_t e;
        snap_t g;
        sw = 4'hC;
        prev = stage;
        @(negedge CLK);
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_next = ~btn_next;
            @(negedge CLK);
            if (stage !== prev) trans++;
            prev = stage;
        end
        btn_next = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK);
            #1;
            if (k == 18) st18 = stage;
            if (k == 19) st19 = stage;
            if (stage !== prev) trans++;
            prev = stage;
        end
        btn_next = 1'b0;
        repeat (25) @(negedge CLK);
        checks++;
        if (st18 !== 2'd0) begin
            errors++;
            $display("FAIL bounce_early got=%0d exp=0", st18);
        end
        checks++;
        if (st19 !== 2'd1) begin
            errors++;
            $display("FAIL bounce_edge got=%0d exp=1", st19);
        end
        checks++;
        if (trans != 1) begin
            errors++;
            $display("FAIL bounce_count got=%0d exp=1", trans);
        end
        model_next(4'hC);
        q.push_back(m);
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL bounce_capture got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_glitch();
        snap_t e;
        snap_t g;
        sw = 4'hA;
        q.push_back(m);
        @(negedge CLK);
        btn_next = 1'b1;
        repeat (DB - 1) @(negedge CLK);
        btn_next = 1'b0;
        repeat (40) @(negedge CLK);
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL glitch_15 got=%h exp=%h", g, e);
        end
        btn_next = 1'b1;
        repeat (DB) @(negedge CLK);
        btn_next = 1'b0;
        repeat (40) @(negedge CLK);
        model_next(4'hA);
        q.push_back(m);
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL glitch_16 got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_clear_priority();
        snap_t e;
        snap_t g;
        checks++;
        if (stage !== 2'd2) begin
            errors++;
            $display("FAIL clr_setup got=%0d exp=2", stage);
        end
        press(1'b1, 1'b1, 4'h3);
        model_reset();
        q.push_back(m);
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL clr_priority got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int trans = 0;
        logic [1:0] prev;
        logic [1:0] st18 = 2'd0;
        logic [1:0] st19 = 2'd0;
        snap_t e;
        snap_t g;
        sw = 4'h7;
        @(negedge CLK);
        btn_next = 1'b1;
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        prev = stage;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK);
            #1;
            if (k == 18) st18 = stage;
            if (k == 19) st19 = stage;
            if (stage !== prev) trans++;
            prev = stage;
        end
        btn_next = 1'b0;
        repeat (25) @(negedge CLK);
        checks++;
        if (st18 !== 2'd0) begin
            errors++;
            $display("FAIL rstdb_early got=%0d exp=0", st18);
        end
        checks++;
        if (st19 !== 2'd1) begin
            errors++;
            $display("FAIL rstdb_edge got=%0d exp=1", st19);
        end
        checks++;
        if (trans != 1) begin
            errors++;
            $display("FAIL rstdb_count got=%0d exp=1", trans);
        end
        model_reset();
        model_next(4'h7);
        q.push_back(m);
        e = q.pop_front();
        g = actual();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL rstdb_state got=%h exp=%h", g, e);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_entry();
        test_sw_no_effect();
        test_bounce();
        test_glitch();
        test_clear_priority();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
